dmem_port_arbiter: RTL and testbench

//  Shares the single-port, word-organised data memory between two requesters:

---
 rtl/dmem_port_arbiter_pkg.sv | 26 ++
 rtl/dmem_port_arbiter_store_be_gen.sv | 29 ++
 rtl/dmem_port_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Build option DMEM_ARB_RR_EN (see dmem_port_arbiter.sv) selects round-robin tie-breaking.
package dmem_port_arbiter_pkg;

   localparam logic [1:0] STORETYPE_SW = 2'b00;
   localparam logic [1:0] STORETYPE_SH = 2'b01;
   localparam logic [1:0] STORETYPE_SB = 2'b10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE,
      RESP  = ST_RESP
   } DmemArbState_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  stype;
   } DmemReq_t;

endpackage

// File: rtl/dmem_port_arbiter_store_be_gen.sv
// Store byte-enable and lane-replicated write-data generator (combinational).
module store_be_gen
   import dmem_port_arbiter_pkg::*;
(
   input  logic [1:0]  stype,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep
);

   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata;
      case (stype)
         STORETYPE_SH: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
         end
         STORETYPE_SB: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         // SW and the reserved encoding write the full word; low address bits ignored
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single-port data RAM (IDLE -> ISSUE -> RESP).
// Define DMEM_ARB_RR_EN for round-robin ties; otherwise port 0 has fixed priority.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [1:0]        p_req_i,
   input  logic [1:0]        p_we_i,
   input  logic [31:0]       p0_addr_i,
   input  logic [31:0]       p1_addr_i,
   input  logic [31:0]       p0_wdata_i,
   input  logic [31:0]       p1_wdata_i,
   input  logic [1:0]        p0_stype_i,
   input  logic [1:0]        p1_stype_i,
   output logic [1:0]        p_gnt_o,
   output logic [1:0]        p_rvalid_o,
   output logic [31:0]       p_rdata_o,
   output logic              mem_en_o,
   output logic [3:0]        mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i
);

   DmemArbState_t state;
   DmemReq_t      sel_req;
   logic          win;
   logic          win_q;
   logic          we_q;
   logic          arb_go;
   logic [3:0]    be;
   logic [31:0]   wdata_rep;
   logic          unused_addr_bits;

`ifdef DMEM_ARB_RR_EN
   logic last_q;
`endif

   always_comb begin
      win = p_req_i[0] ? 1'b0 : 1'b1;
      if (&p_req_i) begin
`ifdef DMEM_ARB_RR_EN
         win = ~last_q;
`else
         win = 1'b0;
`endif
      end
   end

   assign sel_req = win ? DmemReq_t'{p_we_i[1], p1_addr_i, p1_wdata_i, p1_stype_i}
                        : DmemReq_t'{p_we_i[0], p0_addr_i, p0_wdata_i, p0_stype_i};

   assign arb_go = (state != ISSUE) && (|p_req_i);
   assign unused_addr_bits = ^sel_req.addr[31:ADDR_W+2];

   // Encoding sits on the request being latched so the RAM strobes come out registered
   store_be_gen u_be_gen (
      .stype     (sel_req.stype),
      .addr_lo   (sel_req.addr[1:0]),
      .wdata     (sel_req.wdata),
      .be        (be),
      .wdata_rep (wdata_rep)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         p_gnt_o     <= 2'b00;
         p_rvalid_o  <= 2'b00;
         mem_en_o    <= 1'b0;
         mem_we_o    <= 4'b0000;
         mem_addr_o  <= '0;
         mem_wdata_o <= 32'h0;
         win_q       <= 1'b0;
         we_q        <= 1'b0;
`ifdef DMEM_ARB_RR_EN
         last_q      <= 1'b1;
`endif
      end else begin
         p_gnt_o    <= 2'b00;
         p_rvalid_o <= 2'b00;
         mem_en_o   <= 1'b0;
         mem_we_o   <= 4'b0000;
         case (state)
            ISSUE: begin
               state      <= RESP;
               p_rvalid_o <= win_q ? 2'b10 : 2'b01;
            end
            IDLE, RESP: begin
               if (arb_go) begin
                  state       <= ISSUE;
                  p_gnt_o     <= win ? 2'b10 : 2'b01;
                  mem_en_o    <= 1'b1;
                  mem_we_o    <= sel_req.we ? be : 4'b0000;
                  mem_addr_o  <= sel_req.addr[ADDR_W+1:2];
                  mem_wdata_o <= wdata_rep;
                  win_q       <= win;
                  we_q        <= sel_req.we;
`ifdef DMEM_ARB_RR_EN
                  last_q      <= win;
`endif
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // RAM read data lands in the RESP cycle; we_q is stable until the next arbitration edge
   assign p_rdata_o = ((|p_rvalid_o) && !we_q) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed, table-driven bench for dmem_port_arbiter with a 1-cycle-latency RAM model.
module tb_dmem_port_arbiter;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          resetn;
   logic [1:0]    p_req;
   logic [1:0]    p_we;
   logic [31:0]   p0_addr, p1_addr, p0_wdata, p1_wdata;
   logic [1:0]    p0_stype, p1_stype;
   logic [1:0]    p_gnt, p_rvalid;
   logic [31:0]   p_rdata;
   logic          mem_en;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   logic [31:0]   ram [0:(1<<AW)-1];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.ADDR_W(AW)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .p_req_i     (p_req),
      .p_we_i      (p_we),
      .p0_addr_i   (p0_addr),
      .p1_addr_i   (p1_addr),
      .p0_wdata_i  (p0_wdata),
      .p1_wdata_i  (p1_wdata),
      .p0_stype_i  (p0_stype),
      .p1_stype_i  (p1_stype),
      .p_gnt_o     (p_gnt),
      .p_rvalid_o  (p_rvalid),
      .p_rdata_o   (p_rdata),
      .mem_en_o    (mem_en),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   // RAM model: preloaded while reset is held, 1-cycle read latency, byte-lane writes
   always @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < (1 << AW); i++) ram[i] <= 32'h0;
         ram[4] <= 32'hDEADBEEF;
         mem_rdata <= 32'h0;
      end else if (mem_en) begin
         mem_rdata <= ram[mem_addr];
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   typedef struct {
      logic          port;
      logic          we;
      logic [31:0]   addr;
      logic [31:0]   wdata;
      logic [1:0]    stype;
      logic [3:0]    exp_we;
      logic [31:0]   exp_wdata;
      logic [AW-1:0] exp_addr;
      logic [31:0]   exp_rdata;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_gnt"},    {30'd0, p_gnt},    32'h0);
      chk({nm, "_rvalid"}, {30'd0, p_rvalid}, 32'h0);
      chk({nm, "_rdata"},  p_rdata,           32'h0);
      chk({nm, "_mem_en"}, {31'd0, mem_en},   32'h0);
      chk({nm, "_mem_we"}, {28'd0, mem_we},   32'h0);
      chk({nm, "_addr"},   {22'd0, mem_addr}, 32'h0);
      chk({nm, "_wdata"},  mem_wdata,         32'h0);
   endtask

   task automatic idle_inputs();
      p_req = 2'b00; p_we = 2'b00;
      p0_addr = 32'h0; p1_addr = 32'h0; p0_wdata = 32'h0; p1_wdata = 32'h0;
      p0_stype = 2'b00; p1_stype = 2'b00;
   endtask

   task automatic do_access(input vec_t v, input int idx);
      logic [1:0] oh;
      oh = v.port ? 2'b10 : 2'b01;
      if (v.port) begin
         p1_addr = v.addr; p1_wdata = v.wdata; p1_stype = v.stype; p_we[1] = v.we;
      end else begin
         p0_addr = v.addr; p0_wdata = v.wdata; p0_stype = v.stype; p_we[0] = v.we;
      end
      p_req = oh;
      step();
      chk($sformatf("v%0d_gnt", idx),    {30'd0, p_gnt},   {30'd0, oh});
      chk($sformatf("v%0d_mem_en", idx), {31'd0, mem_en},  32'h1);
      chk($sformatf("v%0d_mem_we", idx), {28'd0, mem_we},  {28'd0, v.exp_we});
      chk($sformatf("v%0d_addr", idx),   {22'd0, mem_addr}, {22'd0, v.exp_addr});
      chk($sformatf("v%0d_wdata", idx),  mem_wdata,        v.exp_wdata);
      idle_inputs();
      step();
      chk($sformatf("v%0d_rvalid", idx), {30'd0, p_rvalid}, {30'd0, oh});
      chk($sformatf("v%0d_rdata", idx),  p_rdata,           v.exp_rdata);
      step();
      chk($sformatf("v%0d_rvalid_off", idx), {30'd0, p_rvalid}, 32'h0);
   endtask

   initial begin
      int n, last;
      logic [1:0] exp_g;

      //        port we  addr          wdata         st     be       wdata_rep     addr    rdata
      vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 2'b00, 4'b0000, 32'h0000_0000, 10'h004, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_0023, 32'h0000_00A5, 2'b10, 4'b1000, 32'hA5A5_A5A5, 10'h008, 32'h0};
      vecs[2] = '{1'b0, 1'b1, 32'h0000_0022, 32'h0000_1234, 2'b01, 4'b1100, 32'h1234_1234, 10'h008, 32'h0};
      vecs[3] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0000_0000, 2'b00, 4'b0000, 32'h0000_0000, 10'h008, 32'h1234_0000};
      vecs[4] = '{1'b1, 1'b1, 32'hFFFF_F007, 32'hCAFE_F00D, 2'b11, 4'b1111, 32'hCAFE_F00D, 10'h001, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 2'b00, 4'b0000, 32'h0000_0000, 10'h001, 32'hCAFE_F00D};
      vecs[6] = '{1'b1, 1'b1, 32'h0000_0005, 32'h0000_0077, 2'b10, 4'b0010, 32'h7777_7777, 10'h001, 32'h0};
      vecs[7] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0000_0000, 2'b00, 4'b0000, 32'h0000_0000, 10'h001, 32'hCAFE_770D};
      vecs[8] = '{1'b0, 1'b1, 32'h0000_0040, 32'hABCD_5678, 2'b01, 4'b0011, 32'h5678_5678, 10'h010, 32'h0};
      vecs[9] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_01FF, 2'b10, 4'b0001, 32'hFFFF_FFFF, 10'h000, 32'h0};

      idle_inputs();
      resetn = 1'b0;
      repeat (3) step();
      chk_all_zero("rst");
      resetn = 1'b1;
      step();
      chk_all_zero("post_rst");

      // Reset while a port-0 write is in ISSUE
      p_req = 2'b01; p_we = 2'b01; p0_addr = 32'h0000_0008; p0_wdata = 32'h1111_1111;
      step();
      chk("mid_issue_en", {31'd0, mem_en}, 32'h1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_en_drop", {31'd0, mem_en}, 32'h0);
      idle_inputs();
      step();
      chk("mid_rst_no_rvalid", {30'd0, p_rvalid}, 32'h0);
      resetn = 1'b1;
      step();
      chk_all_zero("mid_rst_release");
      step();
      chk_all_zero("mid_rst_idle");

      for (int i = 0; i < 10; i++) do_access(vecs[i], i);

      // Both ports requesting continuously, starting from a fresh reset
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      step();
      p_req = 2'b11; p_we = 2'b00; p0_addr = 32'h10; p1_addr = 32'h20;
      n = 0; last = -1;
      for (int c = 0; c < 40 && n < 8; c++) begin
         step();
         if (p_gnt != 2'b00) begin
`ifdef DMEM_ARB_RR_EN
            exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            chk($sformatf("tie_gnt%0d", n), {30'd0, p_gnt}, {30'd0, exp_g});
            if (n > 0) chk($sformatf("tie_gap%0d", n), c - last, 2);
            last = c;
            n++;
            if (n == 8) idle_inputs();
         end
      end
      chk("tie_count", n, 8);
      repeat (2) step();

      // Port 0 raises its request during the RESP cycle of a port-1 read
      p_req = 2'b10; p1_addr = 32'h0000_0010;
      step();
      chk("b2b_gnt1", {30'd0, p_gnt}, 32'h2);
      idle_inputs();
      step();
      chk("b2b_rvalid1", {30'd0, p_rvalid}, 32'h2);
      p_req = 2'b01; p0_addr = 32'h0000_0010;
      step();
      chk("b2b_gnt0", {30'd0, p_gnt}, 32'h1);
      chk("b2b_rvalid_off", {30'd0, p_rvalid}, 32'h0);
      idle_inputs();
      step();
      chk("b2b_rvalid0", {30'd0, p_rvalid}, 32'h1);
      chk("b2b_rdata0", p_rdata, 32'hDEADBEEF);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
